// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one shared 1-bit full-adder cell is stepped LSB first
// across the latched operands, one bit per clock, for ADD/SUB/AND/XOR.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_out,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             zero_reg;

  logic             a_bit;
  logic             b_bit;
  logic             b_eff;
  logic             arith;
  logic             ha0_s, ha0_c, ha1_s, ha1_c;
  logic             cell_cout;
  logic             bit_next;
  logic             carry_next;
  logic [WIDTH-1:0] shift_next;
  logic             accept;
  logic             last_bit;

  assign a_bit = a_reg[idx_reg];
  assign b_bit = b_reg[idx_reg];
  assign arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);
  // SUB runs as a + ~b + 1; the +1 comes from the carry preset at accept.
  assign b_eff = b_bit ^ (op_reg == OP_SUB);

  half_adder ha0 (.x(a_bit), .y(b_eff),     .s(ha0_s), .c(ha0_c));
  half_adder ha1 (.x(ha0_s), .y(carry_reg), .s(ha1_s), .c(ha1_c));
  assign cell_cout = ha0_c | ha1_c;

  always_comb begin
    bit_next   = 1'b0;
    carry_next = 1'b0;
    if (arith) begin
      bit_next   = ha1_s;
      carry_next = cell_cout;
    end else if (op_reg == OP_AND) begin
      bit_next = a_bit & b_bit;
    end else begin
      bit_next = a_bit ^ b_bit;
    end
  end

  assign shift_next = {bit_next, shift_reg[WIDTH-1:1]};
  assign accept     = start_in && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit   = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= 2'b00;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      shift_reg     <= '0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          shift_reg <= shift_next;
          carry_reg <= carry_next;
          if (last_bit) begin
            state_reg     <= DONE;
            idx_reg       <= '0;
            result_reg    <= shift_next;
            carry_out_reg <= carry_next;
            zero_reg      <= (shift_next == '0);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state_reg <= RUN;
            a_reg     <= a_in;
            b_reg     <= b_in;
            op_reg    <= op_in;
            idx_reg   <= '0;
            carry_reg <= (op_in == OP_SUB);
            shift_reg <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_out_reg;
  assign zero_out  = zero_reg;
  assign busy      = (state_reg == RUN);
  // DONE lasts exactly one cycle, so the state register itself is the done pulse.
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl with hand-computed expectations.

module tb_alu_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_in = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic [3:0] a_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic [3:0] result;
  logic       carry_out;
  logic       zero_out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_serial_ctrl #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_in(start_in),
    .op_in(op_in),
    .a_in(a_in),
    .b_in(b_in),
    .result(result),
    .carry_out(carry_out),
    .zero_out(zero_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait for done, check latency and flags.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp_r,
                        input logic exp_c, input logic exp_z);
    int n;
    op_in = op; a_in = a; b_in = b; start_in = 1'b1;
    step();
    start_in = 1'b0;
    a_in = 4'h0; b_in = 4'h0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_result"}, {28'd0, result}, {28'd0, exp_r});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check({tag, "_zero"}, {31'd0, zero_out}, {31'd0, exp_z});
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int n;
    int t1;
    int t2;

    step();
    step();
    check("rst_result", {28'd0, result}, 32'd0);
    check("rst_zero", {31'd0, zero_out}, 32'd1);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add1", 2'b00, 4'b0111, 4'b0101, 4'b1100, 1'b0, 1'b0);
    run_op("add2", 2'b00, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
    run_op("sub1", 2'b01, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    run_op("sub2", 2'b01, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0);
    run_op("and", 2'b10, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);
    run_op("xor", 2'b11, 4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0);

    // Start pulse during RUN must be ignored.
    step();
    op_in = 2'b00; a_in = 4'b0001; b_in = 4'b0001; start_in = 1'b1;
    step();
    start_in = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 1) begin
        start_in = 1'b1; b_in = 4'b1111;
      end else begin
        start_in = 1'b0;
      end
      step();
    end
    check("ignore_busy_cycles", busy_cnt, 4);
    check("ignore_done_count", done_cnt, 1);
    check("ignore_result", {28'd0, result}, 32'h2);

    // Back-to-back: start held high, XOR then ADD.
    op_in = 2'b11; a_in = 4'b1111; b_in = 4'b0000; start_in = 1'b1;
    step();
    op_in = 2'b00; a_in = 4'b0010; b_in = 4'b0011;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    t1 = cyc;
    check("b2b_first_result", {28'd0, result}, 32'hF);
    step();
    start_in = 1'b0;
    check("b2b_relaunch_busy", {31'd0, busy}, 32'd1);
    check("b2b_hold_result", {28'd0, result}, 32'hF);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    t2 = cyc;
    check("b2b_spacing", t2 - t1, 5);
    check("b2b_second_result", {28'd0, result}, 32'h5);
    check("b2b_second_carry", {31'd0, carry_out}, 32'd0);

    // Async reset in the middle of an ADD.
    step();
    op_in = 2'b00; a_in = 4'b0111; b_in = 4'b0101; start_in = 1'b1;
    step();
    start_in = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_result", {28'd0, result}, 32'd0);
    check("midrst_zero", {31'd0, zero_out}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
